div_iter: RTL and testbench
===========================

Name: div_iter

Overview:
- Parametrised multicycle iterative divider for the MIPS execute stage.
- Serves both DIV (signed) and DIVU (unsigned) through a per-operation mode input.
- Uses a start/busy/done handshake and a configurable radix (bits retired per cycle).
- Produces quotient (LO) and remainder (HI) with defined divide-by-zero and signed-overflow results.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 2.
- BITS_PER_CYCLE, 1, quotient bits retired per iteration cycle; must divide WIDTH (legal: 1, 2, 4, 8).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- is_signed  in  1  1 = two's-complement DIV, 0 = DIVU; captured with start.
- dividend  in  WIDTH  captured on accepted start.
- divisor  in  WIDTH  captured on accepted start.
- q  out  WIDTH  quotient register (to LO).
- r  out  WIDTH  remainder register (to HI).
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; q/r/div_by_zero are valid from this cycle onward.
- div_by_zero  out  1  registered with q/r; high if the completed operation had divisor == 0.

Behaviour:
- Reset: state = IDLE; q = 0, r = 0, busy = 0, done = 0, div_by_zero = 0; iteration counter = 0.
- Reset has priority over every other event, including mid-operation: the operation is aborted, no done is produced, and q/r are cleared.
- Define N = WIDTH/BITS_PER_CYCLE.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE: start = 1 at edge E0 accepts the operation.
  - Captures is_signed, divisor == 0, the operand signs, and the magnitudes |dividend| and |divisor| (magnitudes only when is_signed = 1).
  - Clears the partial remainder; counter = 0; goes to CALC.
- CALC: each cycle performs BITS_PER_CYCLE restoring shift/compare/subtract steps on a {remainder, quotient} pair of width 2*WIDTH.
  - Compares use a WIDTH+1-bit remainder to avoid carry loss.
  - After N cycles, goes to FIX.
- FIX: applies sign correction.
  - q is negated iff is_signed and the operand signs differ.
  - r is negated iff is_signed and the dividend is negative; the remainder carries the sign of the dividend.
  - At the FIX->IDLE edge, writes q, r and div_by_zero, and raises done for exactly one cycle.
- Timing:
  - busy = 1 from E1 through E(N+1), i.e. N+1 cycles.
  - done is high between E(N+1) and E(N+2).
  - Latency from the start edge to done is N+1 cycles (33 for the defaults).
- Divide by zero:
  - Takes the normal latency.
  - Result is q = all ones and r = dividend as captured (raw, both modes); div_by_zero = 1.
- Signed overflow, most-negative / -1: q = most-negative value, r = 0; no flag. This falls out of magnitude arithmetic truncated to WIDTH.
- start while busy is ignored; the operands in flight are unaffected.
- start in the same cycle as done (state is IDLE) is accepted normally.
- q/r hold the last result indefinitely; they change only at completion or reset.
- Operand inputs may change freely after the accepting edge.

Decomposition:
- Package div_pkg holds:
  - the state enum (IDLE, CALC, FIX);
  - localparam helpers: N = WIDTH/BITS_PER_CYCLE and counter width = $clog2(N+1);
  - a function for two's-complement magnitude/negate.
- Sub-module div_step: purely combinational, one radix-2^BITS_PER_CYCLE restoring step (remainder-in, quotient-in, divisor -> remainder-out, quotient-out).
- div_iter instantiates one div_step and owns all registers and the FSM.

Test Plan:
- DIVU 100 / 7 (WIDTH = 32) -> q = 14, r = 2, div_by_zero = 0; done exactly 33 cycles after the start edge; busy high for 33 cycles.
- DIV -7 / 2 -> q = 0xFFFFFFFD, r = 0xFFFFFFFF. DIV 7 / -2 -> q = 0xFFFFFFFD, r = 1. DIV -7 / -2 -> q = 3, r = 0xFFFFFFFF.
- Divisor 0: dividend 0x00001234, both modes -> q = 0xFFFFFFFF, r = 0x00001234, div_by_zero = 1, normal latency.
- 0x80000000 / 0xFFFFFFFF:
  - DIV -> q = 0x80000000, r = 0.
  - DIVU -> q = 0, r = 0x80000000.
- Handshake/abort:
  - start pulsed at cycle 5 of an op with new operands -> first result unchanged, single done.
  - Back-to-back start on the done cycle -> second op accepted.
  - reset at cycle 10 -> busy = 0 next cycle, no done, q = r = 0.
- BITS_PER_CYCLE = 4: DIVU 0xFFFFFFFF / 0x10 -> q = 0x0FFFFFFF, r = 0xF; done 9 cycles after start.
- Randomised sweep against a reference model for BITS_PER_CYCLE = 1, 2 and 8.

Source files
------------

// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the iterative divider:
//   - div_state_e : FSM state encoding (IDLE, CALC, FIX)
//   - div_iters   : number of iteration cycles N = WIDTH / BITS_PER_CYCLE
//   - div_cnt_w   : iteration counter width, $clog2(N + 1)
//   - div_neg_if  : conditional two's-complement negate, used both to take
//                   operand magnitudes and to apply the final sign correction
// No ports (package).
// ----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    // Widest operand the negate helper handles; callers size-cast to and from it.
    localparam int DIV_MAX_W = 64;

    function automatic int div_iters(input int width, input int bpc);
        return width / bpc;
    endfunction

    function automatic int div_cnt_w(input int width, input int bpc);
        return $clog2((width / bpc) + 1);
    endfunction

    // Returns -v when neg is set, v otherwise. Truncating the result back to the
    // operand width gives the correct WIDTH-bit two's-complement value.
    function automatic logic [DIV_MAX_W-1:0] div_neg_if(input logic [DIV_MAX_W-1:0] v,
                                                        input logic                 neg);
        return neg ? (~v + {{(DIV_MAX_W-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step
// Purely combinational radix-2^BITS_PER_CYCLE restoring division step.
// The {rem, quo} pair is shifted left one bit at a time; after each shift the
// remainder is compared against the divisor and, when large enough, reduced
// by it while a 1 is retired into the quotient LSB.
// Ports:
//   rem_in  [WIDTH-1:0]  partial remainder before this step
//   quo_in  [WIDTH-1:0]  working dividend/quotient before this step
//   divisor [WIDTH-1:0]  divisor magnitude
//   rem_out [WIDTH-1:0]  partial remainder after BITS_PER_CYCLE bits
//   quo_out [WIDTH-1:0]  working dividend/quotient after BITS_PER_CYCLE bits
// ----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0]   rem_ext;
    logic [WIDTH-1:0] rem_w;
    logic [WIDTH-1:0] quo_w;

    always_comb begin
        rem_ext = '0;
        rem_w   = rem_in;
        quo_w   = quo_in;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            // One extra bit keeps the shifted-out remainder MSB; since the
            // remainder was below the divisor, the shifted value is below
            // 2*divisor and a single subtraction restores it into WIDTH bits.
            rem_ext = {rem_w, quo_w[WIDTH-1]};
            quo_w   = {quo_w[WIDTH-2:0], 1'b0};
            if (rem_ext >= {1'b0, divisor}) begin
                rem_ext  = rem_ext - {1'b0, divisor};
                quo_w[0] = 1'b1;
            end
            rem_w = rem_ext[WIDTH-1:0];
        end
    end

    assign rem_out = rem_w;
    assign quo_out = quo_w;

endmodule

// File: rtl/div_iter.sv
// ----------------------------------------------------------------------------
// div_iter
// Multicycle iterative divider for DIV (signed) and DIVU (unsigned).
// Operands are reduced to magnitudes on accept, divided with a restoring
// shift/subtract loop retiring BITS_PER_CYCLE bits per cycle, then sign
// corrected. Result latency from the accepting edge to done is N+1 cycles,
// N = WIDTH / BITS_PER_CYCLE.
// Ports:
//   clock                    rising-edge clock
//   reset                    synchronous active-high reset, aborts any op
//   start                    request, only looked at in IDLE
//   is_signed                1 = DIV, 0 = DIVU, captured with start
//   dividend [WIDTH-1:0]     captured on accepted start
//   divisor  [WIDTH-1:0]     captured on accepted start
//   q        [WIDTH-1:0]     quotient (LO), held until next completion
//   r        [WIDTH-1:0]     remainder (HI), held until next completion
//   busy                     operation in flight
//   done                     single-cycle completion pulse
//   div_by_zero              completed op had a zero divisor
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; results held
// CALC  | N cycles of restoring division on operand magnitudes
// FIX   | sign correction, results written and done raised on exit
// ----------------------------------------------------------------------------
module div_iter
    import div_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int N     = div_iters(WIDTH, BITS_PER_CYCLE);
    localparam int CNT_W = div_cnt_w(WIDTH, BITS_PER_CYCLE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             done_q, done_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] fix_q;
    logic [WIDTH-1:0] fix_r;

    // Signs only matter for DIV; DIVU operands are taken as-is.
    assign dvd_neg = is_signed & dividend[WIDTH-1];
    assign dvs_neg = is_signed & divisor[WIDTH-1];
    assign dvd_mag = WIDTH'(div_neg_if(DIV_MAX_W'(dividend), dvd_neg));
    assign dvs_mag = WIDTH'(div_neg_if(DIV_MAX_W'(divisor), dvs_neg));

    // A zero divisor makes every step subtract 0, so the magnitude loop
    // already yields remainder = |dividend|; re-applying the dividend sign
    // restores the raw dividend. Only the quotient must be forced.
    assign fix_q = dbz_q ? '1 : WIDTH'(div_neg_if(DIV_MAX_W'(quo_q), q_neg_q));
    assign fix_r = WIDTH'(div_neg_if(DIV_MAX_W'(rem_q), r_neg_q));

    div_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvsr_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvsr_q        <= '0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            dbz_q         <= 1'b0;
            q_q           <= '0;
            r_q           <= '0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            dvsr_q        <= dvsr_d;
            q_neg_q       <= q_neg_d;
            r_neg_q       <= r_neg_d;
            dbz_q         <= dbz_d;
            q_q           <= q_d;
            r_q           <= r_d;
            done_q        <= done_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (cnt_q == CNT_LAST) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values.
    always_comb begin
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        dvsr_d        = dvsr_q;
        q_neg_d       = q_neg_q;
        r_neg_d       = r_neg_q;
        dbz_d         = dbz_q;
        q_d           = q_q;
        r_d           = r_q;
        done_d        = 1'b0;
        div_by_zero_d = div_by_zero_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = dvd_mag;
                    dvsr_d  = dvs_mag;
                    q_neg_d = dvd_neg ^ dvs_neg;
                    r_neg_d = dvd_neg;
                    dbz_d   = (divisor == '0);
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
            end
            FIX: begin
                q_d           = fix_q;
                r_d           = fix_r;
                div_by_zero_d = dbz_q;
                done_d        = 1'b1;
            end
            default: ;
        endcase
    end

    // Outputs.
    always_comb begin
        busy        = (state_q != IDLE);
        done        = done_q;
        q           = q_q;
        r           = r_q;
        div_by_zero = div_by_zero_q;
    end

endmodule

// File: tb/tb_div_iter.sv
module tb_div_iter;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_a [4];
    logic        sgn_a   [4];
    logic [31:0] dvd_a   [4];
    logic [31:0] dvs_a   [4];
    logic [31:0] q_a     [4];
    logic [31:0] r_a     [4];
    logic        busy_a  [4];
    logic        done_a  [4];
    logic        dbz_a   [4];

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    // Index k holds a divider with BITS_PER_CYCLE = 1 << k.
    div_iter #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .clock(clock), .reset(reset), .start(start_a[0]), .is_signed(sgn_a[0]),
        .dividend(dvd_a[0]), .divisor(dvs_a[0]), .q(q_a[0]), .r(r_a[0]),
        .busy(busy_a[0]), .done(done_a[0]), .div_by_zero(dbz_a[0]));
    div_iter #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut2 (
        .clock(clock), .reset(reset), .start(start_a[1]), .is_signed(sgn_a[1]),
        .dividend(dvd_a[1]), .divisor(dvs_a[1]), .q(q_a[1]), .r(r_a[1]),
        .busy(busy_a[1]), .done(done_a[1]), .div_by_zero(dbz_a[1]));
    div_iter #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
        .clock(clock), .reset(reset), .start(start_a[2]), .is_signed(sgn_a[2]),
        .dividend(dvd_a[2]), .divisor(dvs_a[2]), .q(q_a[2]), .r(r_a[2]),
        .busy(busy_a[2]), .done(done_a[2]), .div_by_zero(dbz_a[2]));
    div_iter #(.WIDTH(32), .BITS_PER_CYCLE(8)) dut8 (
        .clock(clock), .reset(reset), .start(start_a[3]), .is_signed(sgn_a[3]),
        .dividend(dvd_a[3]), .divisor(dvs_a[3]), .q(q_a[3]), .r(r_a[3]),
        .busy(busy_a[3]), .done(done_a[3]), .div_by_zero(dbz_a[3]));

    function automatic int lat_of(input int k);
        return 32 / (1 << k) + 1;
    endfunction

    // Reference: MIPS DIV/DIVU semantics with plain 64-bit arithmetic.
    // Truncating division gives a remainder with the dividend's sign, and
    // truncating min/-1 to 32 bits yields q = min, r = 0.
    function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] rq, output logic [31:0] rr,
                                    output logic rz);
        longint sa, sb, lq, lr;
        rz = (b == 32'd0);
        if (b == 32'd0) begin
            rq = 32'hFFFF_FFFF;
            rr = a;
        end else begin
            if (sgn) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'(a);
                sb = longint'(b);
            end
            lq = sa / sb;
            lr = sa % sb;
            rq = lq[31:0];
            rr = lr[31:0];
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one operation on divider k and waits for done (bounded).
    task automatic run_op(input int k, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, output int lat, output int busy_cnt);
        @(negedge clock);
        start_a[k] = 1'b1;
        sgn_a[k]   = sgn;
        dvd_a[k]   = a;
        dvs_a[k]   = b;
        @(posedge clock);
        #1;
        start_a[k] = 1'b0;
        sgn_a[k]   = 1'($urandom);
        dvd_a[k]   = $urandom;
        dvs_a[k]   = $urandom;
        lat        = 0;
        busy_cnt   = int'(busy_a[k]);
        while (lat < 200) begin
            @(posedge clock);
            #1;
            lat++;
            if (done_a[k]) break;
            busy_cnt += int'(busy_a[k]);
        end
    endtask

    task automatic do_op(input string tag, input int k, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eq, er;
        logic        ez;
        int          lat, bc;
        ref_div(sgn, a, b, eq, er, ez);
        run_op(k, sgn, a, b, lat, bc);
        check({tag, ".q"}, q_a[k], eq);
        check({tag, ".r"}, r_a[k], er);
        check({tag, ".dbz"}, 32'(dbz_a[k]), 32'(ez));
        check({tag, ".lat"}, 32'(lat), 32'(lat_of(k)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, bc, ndone;
        logic [31:0] a, b;
        logic        sgn;

        for (int k = 0; k < 4; k++) begin
            start_a[k] = 1'b0;
            sgn_a[k]   = 1'b0;
            dvd_a[k]   = '0;
            dvs_a[k]   = '0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst.q",    q_a[0], 32'd0);
        check("rst.r",    r_a[0], 32'd0);
        check("rst.busy", 32'(busy_a[0]), 32'd0);
        check("rst.done", 32'(done_a[0]), 32'd0);
        check("rst.dbz",  32'(dbz_a[0]), 32'd0);
        reset = 1'b0;

        // DIVU 100 / 7 with busy length and single-cycle done.
        run_op(0, 1'b0, 32'd100, 32'd7, lat, bc);
        check("divu100_7.q",    q_a[0], 32'd14);
        check("divu100_7.r",    r_a[0], 32'd2);
        check("divu100_7.dbz",  32'(dbz_a[0]), 32'd0);
        check("divu100_7.lat",  32'(lat), 32'd33);
        check("divu100_7.busy", 32'(bc), 32'd33);
        @(posedge clock);
        #1;
        check("divu100_7.pulse", 32'(done_a[0]), 32'd0);
        check("divu100_7.hold",  q_a[0], 32'd14);

        // Signed sign-correction cases.
        do_op("div_m7_2",  0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        check("div_m7_2.qabs", q_a[0], 32'hFFFF_FFFD);
        check("div_m7_2.rabs", r_a[0], 32'hFFFF_FFFF);
        do_op("div_7_m2",  0, 1'b1, 32'd7, 32'hFFFF_FFFE);
        check("div_7_m2.rabs", r_a[0], 32'd1);
        do_op("div_m7_m2", 0, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
        check("div_m7_m2.qabs", q_a[0], 32'd3);

        // Divide by zero, both modes, plus a negative signed dividend.
        do_op("dbz_u", 0, 1'b0, 32'h0000_1234, 32'd0);
        check("dbz_u.qabs", q_a[0], 32'hFFFF_FFFF);
        check("dbz_u.rabs", r_a[0], 32'h0000_1234);
        do_op("dbz_s", 0, 1'b1, 32'h0000_1234, 32'd0);
        check("dbz_s.flag", 32'(dbz_a[0]), 32'd1);
        do_op("dbz_sneg", 0, 1'b1, 32'h8000_1234, 32'd0);

        // Most-negative / -1.
        do_op("ovf_s", 0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check("ovf_s.qabs", q_a[0], 32'h8000_0000);
        check("ovf_s.rabs", r_a[0], 32'd0);
        do_op("ovf_u", 0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        check("ovf_u.rabs", r_a[0], 32'h8000_0000);

        // Radix-16 case.
        do_op("bpc4", 2, 1'b0, 32'hFFFF_FFFF, 32'h10);
        check("bpc4.qabs", q_a[2], 32'h0FFF_FFFF);
        check("bpc4.rabs", r_a[2], 32'hF);

        // start while busy is ignored.
        @(negedge clock);
        start_a[0] = 1'b1; sgn_a[0] = 1'b0; dvd_a[0] = 32'd100; dvs_a[0] = 32'd7;
        @(posedge clock);
        #1;
        start_a[0] = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clock);
            #1;
            if (done_a[0]) ndone++;
            if (c == 5) begin
                start_a[0] = 1'b1; sgn_a[0] = 1'b1; dvd_a[0] = 32'd1000; dvs_a[0] = 32'd3;
            end
            if (c == 6) start_a[0] = 1'b0;
        end
        check("midstart.q",     q_a[0], 32'd14);
        check("midstart.r",     r_a[0], 32'd2);
        check("midstart.ndone", 32'(ndone), 32'd1);
        check("midstart.busy",  32'(busy_a[0]), 32'd0);

        // Back-to-back: start on the done cycle.
        run_op(0, 1'b0, 32'd1000, 32'd3, lat, bc);
        check("b2b1.q", q_a[0], 32'd333);
        start_a[0] = 1'b1; sgn_a[0] = 1'b0; dvd_a[0] = 32'd77; dvs_a[0] = 32'd5;
        @(posedge clock);
        #1;
        start_a[0] = 1'b0;
        check("b2b.accept", 32'(busy_a[0]), 32'd1);
        check("b2b.hold",   q_a[0], 32'd333);
        lat = 0;
        while (lat < 200) begin
            @(posedge clock);
            #1;
            lat++;
            if (done_a[0]) break;
        end
        check("b2b2.q",   q_a[0], 32'd15);
        check("b2b2.r",   r_a[0], 32'd2);
        check("b2b2.lat", 32'(lat), 32'd33);

        // Reset mid-operation aborts.
        @(negedge clock);
        start_a[0] = 1'b1; sgn_a[0] = 1'b0; dvd_a[0] = 32'h0000_FFFF; dvs_a[0] = 32'd3;
        @(posedge clock);
        #1;
        start_a[0] = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort.busy", 32'(busy_a[0]), 32'd0);
        check("abort.done", 32'(done_a[0]), 32'd0);
        check("abort.q",    q_a[0], 32'd0);
        check("abort.r",    r_a[0], 32'd0);
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (done_a[0]) ndone++;
        end
        check("abort.ndone", 32'(ndone), 32'd0);

        // Randomised sweep on all radices.
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 30; n++) begin
                sgn = 1'($urandom);
                a   = $urandom;
                case ($urandom_range(0, 7))
                    0:       b = 32'd0;
                    1:       b = $urandom_range(1, 15);
                    2:       b = 32'hFFFF_FFFF;
                    3:       b = $urandom >> $urandom_range(0, 31);
                    default: b = $urandom;
                endcase
                if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
                do_op($sformatf("rnd.k%0d.n%0d", k, n), k, sgn, a, b);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
